ucontrol_sequencer: RTL and testbench
=====================================

# ucontrol_sequencer

Microprogram sequencer for the micro-datapath control unit. It holds the control store address register (CSAR) and evaluates the microinstruction COND field against the ALU flags and IR bit 13 to produce the 2-bit branch type that steers the next-address multiplexer. It also produces the incremented address and stalls the microprogram while a memory access is pending. It closes the loop with the next-address multiplexer: this block drives `Tipo` and `CSAI` into the mux and registers the mux's `CSAddress` result back into CSAR.

## Interface

Parameters:
- `DATAWIDTH_CSADDRESS`, 11, control store address width.
- `DATAWIDTH_COND`, 3, microinstruction COND field width.
- `DATAWIDTH_CBL`, 2, branch type width.
- `TIMEOUT_CYCLES`, 16, stall cycles before watchdog trap. Used only with `UCSEQ_STALL_TIMEOUT_EN`.
- `TRAP_ADDRESS`, 11'h7F0, control store address loaded on watchdog trap.

Ports:
- `UCSEQ_CLOCK_50`, in, 1, system clock; all state changes on the rising edge.
- `UCSEQ_ResetInLow_In`, in, 1, asynchronous active-low reset.
- `UCSEQ_CSAddress_InBus`, in, `DATAWIDTH_CSADDRESS`, next address returned by the next-address mux.
- `UCSEQ_Cond_InBus`, in, `DATAWIDTH_COND`, COND field of the current microinstruction.
- `UCSEQ_Flags_InBus`, in, 4, PSR flags {n,z,v,c}.
- `UCSEQ_IR13_In`, in, 1, IR bit 13.
- `UCSEQ_MemReq_In`, in, 1, current microinstruction performs a memory RD or WR.
- `UCSEQ_MemAck_In`, in, 1, memory completes the access in this cycle.
- `UCSEQ_Halt_In`, in, 1, freezes CSAR while high.
- `UCSEQ_CSAR_OutBus`, out, `DATAWIDTH_CSADDRESS`, registered control store address.
- `UCSEQ_CSAI_OutBus`, out, `DATAWIDTH_CSADDRESS`, CSAR+1, combinational.
- `UCSEQ_Tipo_OutBus`, out, `DATAWIDTH_CBL`, branch type: 00 next, 01 jump, 10 decode.
- `UCSEQ_Stall_Out`, out, 1, microprogram is held waiting for memory.
- `UCSEQ_Timeout_Out`, out, 1, one-cycle watchdog trap pulse. Tied 0 without the macro.

## Operation

**States**
- RUN, STALL, plus TRAP when the macro is compiled in.

**Branch type** (combinational, from COND)
- 000 → next (00).
- 001 → jump (01) if n, else next.
- 010 → jump if z, else next.
- 011 → jump if c, else next.
- 100 → jump if v, else next.
- 101 → jump if IR13, else next.
- 110 → jump unconditionally.
- 111 → decode (10).

**CSAI**
- CSAI = CSAR+1, truncated to `DATAWIDTH_CSADDRESS` bits.
- Wraps 11'h7FF → 11'h000.

**RUN**
- If `MemReq`=1 and `MemAck`=0: go to STALL and hold CSAR.
- Otherwise: CSAR ← `CSAddress_InBus`.

**STALL**
- CSAR holds and `Stall_Out`=1.
- `Tipo` is still driven from COND and has no effect, because CSAR does not load.
- On `MemAck`=1: CSAR ← `CSAddress_InBus` and go to RUN.

**Halt**
- `Halt_In`=1 overrides both RUN and STALL loads: CSAR holds and the state holds.
- `MemAck` arriving while halted is ignored. Memory must hold ack until halt releases.

**Reset**
- Asynchronous on `ResetInLow`=0.
- CSAR=0, state RUN, `Stall_Out`=0, `Timeout_Out`=0, watchdog counter=0.
- Reset asserted mid-STALL abandons the access immediately.

## Timing

- One microinstruction per cycle in RUN. CSAR updates on the edge after the address is presented.
- Zero-wait memory: `MemReq` and `MemAck` high in the same cycle → no stall; CSAR advances on the next edge.
- N-wait memory: `Stall_Out` rises on the edge after `MemReq` is seen without ack. CSAR advances on the edge where `MemAck`=1 is sampled.
- `Stall_Out` is registered. `Tipo` and `CSAI` are combinational, with one-level logic from their inputs.
- After reset release, the first CSAR load occurs on the first rising edge.

## Configuration

Macro `UCSEQ_STALL_TIMEOUT_EN`.

**Defined**
- A stall cycle counter counts the cycles spent in STALL.
- When the count reaches `TIMEOUT_CYCLES` without `MemAck`:
  - state → TRAP for one cycle;
  - CSAR ← `TRAP_ADDRESS`;
  - `Timeout_Out`=1 for exactly that cycle;
  - counter cleared;
  - state → RUN.
- `MemAck` in the same cycle as the limit is reached wins: normal load, no trap.
- Halt freezes the counter.

**Undefined**
- No counter and no TRAP state; STALL waits indefinitely.
- `Timeout_Out` is constant 0.

## Test plan

- **Reset:** assert reset mid-stall → CSAR=0, `Stall_Out`=0 immediately, without waiting for a clock edge.
- **Branch table:** sweep COND 000–111 with flags {n,z,v,c}=4'b1010, IR13=1 → `Tipo` = 00, 01, 00, 00, 01, 01, 01, 10.
- **Wrap:** CSAR=11'h7FF → CSAI=11'h000. Feed `CSAddress_InBus`=CSAI → CSAR=0 on the next edge.
- **Memory handshake:**
  - `MemReq`=1 with `MemAck` after 3 cycles → `Stall_Out` high for 3 cycles; CSAR holds, then loads the input.
  - Same-cycle ack → no stall.
- **Halt:** `Halt_In`=1 for 5 cycles during RUN → CSAR unchanged; resumes loading the cycle after release.
- **Timeout (macro defined):** `TIMEOUT_CYCLES`=16, no ack → CSAR=11'h7F0 and `Timeout_Out` 1-cycle pulse after the 16th stall cycle. With ack on cycle 16 → no trap.

Source files
------------

// File: rtl/ucontrol_sequencer_if.sv
// ucontrol_sequencer_if
// Bundles the sequencer's datapath-facing signals: the next-address mux
// loop (CSAddress in, CSAR/CSAI/Tipo out), the microinstruction COND
// field, PSR flags, IR bit 13, the memory handshake and halt.
//   master : datapath / control store side (drives inputs, observes outputs)
//   slave  : the sequencer itself
interface ucontrol_sequencer_if #(
  parameter int DATAWIDTH_CSADDRESS = 11,
  parameter int DATAWIDTH_COND      = 3,
  parameter int DATAWIDTH_CBL       = 2
);
  logic [DATAWIDTH_CSADDRESS-1:0] UCSEQ_CSAddress_InBus;
  logic [DATAWIDTH_COND-1:0]      UCSEQ_Cond_InBus;
  logic [3:0]                     UCSEQ_Flags_InBus;
  logic                           UCSEQ_IR13_In;
  logic                           UCSEQ_MemReq_In;
  logic                           UCSEQ_MemAck_In;
  logic                           UCSEQ_Halt_In;
  logic [DATAWIDTH_CSADDRESS-1:0] UCSEQ_CSAR_OutBus;
  logic [DATAWIDTH_CSADDRESS-1:0] UCSEQ_CSAI_OutBus;
  logic [DATAWIDTH_CBL-1:0]       UCSEQ_Tipo_OutBus;
  logic                           UCSEQ_Stall_Out;
  logic                           UCSEQ_Timeout_Out;

  modport master (
    output UCSEQ_CSAddress_InBus, UCSEQ_Cond_InBus, UCSEQ_Flags_InBus,
           UCSEQ_IR13_In, UCSEQ_MemReq_In, UCSEQ_MemAck_In, UCSEQ_Halt_In,
    input  UCSEQ_CSAR_OutBus, UCSEQ_CSAI_OutBus, UCSEQ_Tipo_OutBus,
           UCSEQ_Stall_Out, UCSEQ_Timeout_Out
  );

  modport slave (
    input  UCSEQ_CSAddress_InBus, UCSEQ_Cond_InBus, UCSEQ_Flags_InBus,
           UCSEQ_IR13_In, UCSEQ_MemReq_In, UCSEQ_MemAck_In, UCSEQ_Halt_In,
    output UCSEQ_CSAR_OutBus, UCSEQ_CSAI_OutBus, UCSEQ_Tipo_OutBus,
           UCSEQ_Stall_Out, UCSEQ_Timeout_Out
  );
endinterface

// File: rtl/ucontrol_sequencer.sv
// ucontrol_sequencer
// Microprogram sequencer: holds the control store address register (CSAR),
// decodes the COND field into the branch type (Tipo) for the next-address
// mux, provides CSAR+1 (CSAI) and stalls while a memory access is pending.
// Ports:
//   UCSEQ_CLOCK_50       : system clock, rising edge
//   UCSEQ_ResetInLow_In  : asynchronous active-low reset
//   bus (slave modport)  : CSAddress/COND/flags/IR13/MemReq/MemAck/Halt in,
//                          CSAR/CSAI/Tipo/Stall/Timeout out
// Optional feature: define UCSEQ_STALL_TIMEOUT_EN to add the stall watchdog
// (TRAP state, jump to TRAP_ADDRESS, one-cycle Timeout pulse). Without it
// STALL waits indefinitely and Timeout is tied low.
//
// state | meaning
// RUN   | one microinstruction per cycle, CSAR loads the mux result
// STALL | memory access pending, CSAR held until MemAck
// TRAP  | watchdog fired, CSAR holds TRAP_ADDRESS for one cycle (macro only)
module ucontrol_sequencer #(
  parameter int          DATAWIDTH_CSADDRESS = 11,
  parameter int          DATAWIDTH_COND      = 3,
  parameter int          DATAWIDTH_CBL       = 2,
  parameter int          TIMEOUT_CYCLES      = 16,
  parameter int unsigned TRAP_ADDRESS        = 'h7F0
) (
  input logic                UCSEQ_CLOCK_50,
  input logic                UCSEQ_ResetInLow_In,
  ucontrol_sequencer_if.slave bus
);

  localparam int W = DATAWIDTH_CSADDRESS;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (TRAP_ADDRESS >= (64'd1 << W)) begin : g_bad_trap
    $error("TRAP_ADDRESS does not fit the control store address width");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
`ifdef UCSEQ_STALL_TIMEOUT_EN
    ,ST_TRAP = 2'd2
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   csar_q, csar_d;
  logic           stall_q;

  // Branch type decode, flags are {n,z,v,c}.
  logic jump_cond;
  always_comb begin
    jump_cond = 1'b0;
    case (bus.UCSEQ_Cond_InBus[2:0])
      3'b001:  jump_cond = bus.UCSEQ_Flags_InBus[3];
      3'b010:  jump_cond = bus.UCSEQ_Flags_InBus[2];
      3'b011:  jump_cond = bus.UCSEQ_Flags_InBus[0];
      3'b100:  jump_cond = bus.UCSEQ_Flags_InBus[1];
      3'b101:  jump_cond = bus.UCSEQ_IR13_In;
      3'b110:  jump_cond = 1'b1;
      default: jump_cond = 1'b0;
    endcase
  end

  always_comb begin
    bus.UCSEQ_Tipo_OutBus = '0;
    if (bus.UCSEQ_Cond_InBus[2:0] == 3'b111)
      bus.UCSEQ_Tipo_OutBus = DATAWIDTH_CBL'(2'b10);
    else if (jump_cond)
      bus.UCSEQ_Tipo_OutBus = DATAWIDTH_CBL'(2'b01);
  end

  assign bus.UCSEQ_CSAI_OutBus = csar_q + W'(1);
  assign bus.UCSEQ_CSAR_OutBus = csar_q;
  assign bus.UCSEQ_Stall_Out   = stall_q;

`ifdef UCSEQ_STALL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Down-counter loaded on STALL entry; reaching zero while still stalled
  // on a non-halted cycle means the TIMEOUT_CYCLES-th stall cycle ended
  // without an ack.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;
`endif

  always_comb begin
    state_d = state_q;
    csar_d  = csar_q;
`ifdef UCSEQ_STALL_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (!bus.UCSEQ_Halt_In) begin
      case (state_q)
        ST_RUN: begin
          if (bus.UCSEQ_MemReq_In && !bus.UCSEQ_MemAck_In) begin
            state_d = ST_STALL;
`ifdef UCSEQ_STALL_TIMEOUT_EN
            cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            csar_d = bus.UCSEQ_CSAddress_InBus;
          end
        end
        ST_STALL: begin
          // Ack on the limit cycle wins over the watchdog.
          if (bus.UCSEQ_MemAck_In) begin
            state_d = ST_RUN;
            csar_d  = bus.UCSEQ_CSAddress_InBus;
`ifdef UCSEQ_STALL_TIMEOUT_EN
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ST_TRAP;
            csar_d  = W'(TRAP_ADDRESS);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
`endif
          end
        end
`ifdef UCSEQ_STALL_TIMEOUT_EN
        ST_TRAP: state_d = ST_RUN;
`endif
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge UCSEQ_CLOCK_50 or negedge UCSEQ_ResetInLow_In) begin
    if (!UCSEQ_ResetInLow_In) begin
      state_q <= ST_RUN;
      csar_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      csar_q  <= csar_d;
      stall_q <= (state_d == ST_STALL);
    end
  end

`ifdef UCSEQ_STALL_TIMEOUT_EN
  always_ff @(posedge UCSEQ_CLOCK_50 or negedge UCSEQ_ResetInLow_In) begin
    if (!UCSEQ_ResetInLow_In) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= (state_d == ST_TRAP);
    end
  end

  assign bus.UCSEQ_Timeout_Out = timeout_q;
`else
  assign bus.UCSEQ_Timeout_Out = 1'b0;
`endif

endmodule

// File: tb/tb_ucontrol_sequencer.sv
// tb_ucontrol_sequencer
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural model of the sequencer.
module tb_ucontrol_sequencer;
  localparam int          W       = 11;
  localparam int          TIMEOUT = 16;
  localparam logic [10:0] TRAP    = 11'h7F0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ucontrol_sequencer_if #(.DATAWIDTH_CSADDRESS(W)) bus ();

  ucontrol_sequencer #(
    .DATAWIDTH_CSADDRESS(W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TRAP_ADDRESS(32'h7F0)
  ) dut (
    .UCSEQ_CLOCK_50(clk),
    .UCSEQ_ResetInLow_In(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [10:0] m_csar  = '0;
  bit          m_stall = 1'b0;
  bit          m_trap  = 1'b0;
  int          m_wait  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_tipo(input logic [2:0] cond, input logic [3:0] flags,
                                          input logic ir13);
    // index = COND, flags = {n,z,v,c}
    bit taken [8];
    taken = '{1'b0, flags[3], flags[2], flags[0], flags[1], ir13, 1'b1, 1'b0};
    if (cond == 3'd7) return 2'b10;
    return taken[cond] ? 2'b01 : 2'b00;
  endfunction

  task automatic model_reset();
    m_csar = '0; m_stall = 1'b0; m_trap = 1'b0; m_wait = 0;
  endtask

  task automatic model_edge(input logic [10:0] addr, input bit req, input bit ack, input bit halt);
    if (halt) return;
    if (m_trap) begin
      m_trap = 1'b0;
    end else if (!m_stall) begin
      if (req && !ack) begin
        m_stall = 1'b1;
        m_wait  = 0;
      end else begin
        m_csar = addr;
      end
    end else if (ack) begin
      m_stall = 1'b0;
      m_csar  = addr;
    end else begin
      m_wait++;
`ifdef UCSEQ_STALL_TIMEOUT_EN
      if (m_wait == TIMEOUT) begin
        m_stall = 1'b0;
        m_trap  = 1'b1;
        m_csar  = TRAP;
      end
`endif
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1 with inputs still applied.
  task automatic cycle(input logic [10:0] addr, input logic [2:0] cond, input logic [3:0] flags,
                       input bit ir13, input bit req, input bit ack, input bit halt);
    logic [10:0] inc;
    bus.UCSEQ_CSAddress_InBus = addr;
    bus.UCSEQ_Cond_InBus      = cond;
    bus.UCSEQ_Flags_InBus     = flags;
    bus.UCSEQ_IR13_In         = ir13;
    bus.UCSEQ_MemReq_In       = req;
    bus.UCSEQ_MemAck_In       = ack;
    bus.UCSEQ_Halt_In         = halt;
    @(negedge clk);
    inc = m_csar + 11'd1;
    check("csar",    32'(bus.UCSEQ_CSAR_OutBus), 32'(m_csar));
    check("csai",    32'(bus.UCSEQ_CSAI_OutBus), 32'(inc));
    check("tipo",    32'(bus.UCSEQ_Tipo_OutBus), 32'(ref_tipo(cond, flags, ir13)));
    check("stall",   32'(bus.UCSEQ_Stall_Out),   32'(m_stall));
    check("timeout", 32'(bus.UCSEQ_Timeout_Out), 32'(m_trap));
    @(posedge clk);
    model_edge(addr, req, ack, halt);
    #1;
  endtask

  task automatic plain(input logic [10:0] addr);
    cycle(addr, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem(input logic [10:0] addr, input bit req, input bit ack);
    cycle(addr, 3'd6, 4'd0, 1'b0, req, ack, 1'b0);
  endtask

  logic [1:0]  tipo_table [8];
  logic [10:0] held;

  initial begin
    tipo_table = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    bus.UCSEQ_CSAddress_InBus = '0;
    bus.UCSEQ_Cond_InBus      = '0;
    bus.UCSEQ_Flags_InBus     = '0;
    bus.UCSEQ_IR13_In         = 1'b0;
    bus.UCSEQ_MemReq_In       = 1'b0;
    bus.UCSEQ_MemAck_In       = 1'b0;
    bus.UCSEQ_Halt_In         = 1'b0;
    model_reset();

    #12;
    check("rst_csar",  32'(bus.UCSEQ_CSAR_OutBus), 32'd0);
    check("rst_stall", 32'(bus.UCSEQ_Stall_Out),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Branch table sweep with {n,z,v,c}=1010, IR13=1
    for (int c = 0; c < 8; c++) begin
      cycle(11'($urandom_range(0, 2047)), 3'(c), 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
      check("tipo_table", 32'(bus.UCSEQ_Tipo_OutBus), 32'(tipo_table[c]));
    end

    // Wrap: CSAR = 7FF, then feed CSAI back
    plain(11'h7FF);
    check("wrap_csar", 32'(bus.UCSEQ_CSAR_OutBus), 32'h7FF);
    check("wrap_csai", 32'(bus.UCSEQ_CSAI_OutBus), 32'h000);
    plain(bus.UCSEQ_CSAI_OutBus);
    check("wrap_load", 32'(bus.UCSEQ_CSAR_OutBus), 32'h000);

    // Three-wait access, then zero-wait access
    plain(11'h123);
    mem(11'h200, 1'b1, 1'b0);
    mem(11'h201, 1'b1, 1'b0);
    mem(11'h202, 1'b1, 1'b0);
    mem(11'h234, 1'b1, 1'b1);
    check("hs_load", 32'(bus.UCSEQ_CSAR_OutBus), 32'h234);
    mem(11'h345, 1'b1, 1'b1);
    check("zw_nostall", 32'(bus.UCSEQ_Stall_Out), 32'd0);
    check("zw_load",    32'(bus.UCSEQ_CSAR_OutBus), 32'h345);

    // Halt for 5 cycles during RUN
    held = bus.UCSEQ_CSAR_OutBus;
    for (int i = 0; i < 5; i++)
      cycle(11'($urandom_range(0, 2047)), 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("halt_hold", 32'(bus.UCSEQ_CSAR_OutBus), 32'(held));
    plain(11'h0AB);
    check("halt_resume", 32'(bus.UCSEQ_CSAR_OutBus), 32'h0AB);

    // Long stall without ack (trap with the watchdog, endless wait without)
    mem(11'h111, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT + 2; i++) mem(11'h050, 1'b0, 1'b0);
    mem(11'h051, 1'b0, 1'b1);
    plain(11'h060);
    plain(11'h061);

    // Ack on the 16th stall cycle: no trap
    mem(11'h111, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) mem(11'h070, 1'b0, 1'b0);
    mem(11'h072, 1'b0, 1'b1);
    check("ack16_load", 32'(bus.UCSEQ_CSAR_OutBus), 32'h072);
    plain(11'h073);

    // Reset mid-stall takes effect without a clock edge
    plain(11'h3C3);
    mem(11'h111, 1'b1, 1'b0);
    mem(11'h112, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_csar",  32'(bus.UCSEQ_CSAR_OutBus), 32'd0);
    check("rst_mid_stall", 32'(bus.UCSEQ_Stall_Out),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
